instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Producer side of the instruction decoder interface. Owns the PC, fetches 32-bit words
//  from instruction memory over a req/gnt/rvalid handshake, and presents one instruction
//  at a time to the decoder. When downstream accepts, it computes the next PC from the
//  decoder's PC_MUX_SEL, the branch condition, rs and the instruction fields.
//  One instruction is in flight at a time; there is no speculation.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word-aligned
//  CNT_W      32             width of the retired-instruction counter
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  imem_req      out  1      fetch request, held until imem_gnt
//  imem_addr     out  32     fetch address; equals pc
//  imem_gnt      in   1      memory accepted the request this cycle
//  imem_rvalid   in   1      imem_rdata valid
//  imem_rdata    in   32     fetched instruction word
//  imem_err      in   1      bus error, qualified by imem_rvalid
//  instruction   out  32     instruction register to the decoder
//  instr_valid   out  1      instruction is valid and held stable
//  instr_ready   in   1      downstream accepts; the control inputs below are valid this cycle
//  pc_mux_sel    in   2      0 seq, 1 register, 2 branch, 3 jump (from the decoder)
//  bcond         in   1      branch condition result for the held instruction
//  rs_val        in   32     GPR[rs] for jr/jalr
//  link_pc       out  32     pc+4 of the held instruction (jal/jalr link value)
//  fault         out  1      sticky: misaligned target or imem_err
//  retired_cnt   out  CNT_W  count of accepted instructions
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, pc=RESET_PC, instruction=0, retired_cnt=0.
//   - instr_valid=0, imem_req=0, fault=0.
//  FSM states IDLE, REQ, WAIT, HOLD, FAULT:
//   - IDLE: always -> REQ on the next cycle. First request is issued in the 2nd cycle after reset release.
//   - REQ: imem_req=1, imem_addr=pc. On imem_gnt -> WAIT.
//   - WAIT: on imem_rvalid & !imem_err, capture rdata into instruction -> HOLD.
//     On imem_rvalid & imem_err -> FAULT. rvalid is never expected in the gnt cycle; it is ignored in REQ.
//   - HOLD: instr_valid=1; instruction and link_pc stay stable until instr_ready.
//     On instr_ready: pc<=next_pc, retired_cnt+=1 (wraps modulo 2^CNT_W), -> REQ.
//     If next_pc[1:0]!=0: pc is not updated, -> FAULT (the retire still counts).
//   - FAULT: fault=1, imem_req=0, instr_valid=0. Exit only by reset.
//  Fetch latency: minimum 3 cycles from a HOLD accept to the next instr_valid, with gnt in the REQ
//  cycle and rvalid on the following cycle.
//  next_pc, with p4=pc+4 (32-bit, wraps at 2^32):
//   - sel 0: p4
//   - sel 1: rs_val
//   - sel 2: bcond ? p4 + {{14{imm[15]}},imm,2'b00} : p4, using imm=instruction[15:0]; 32-bit wrap
//   - sel 3: {p4[31:28], instruction[25:0], 2'b00}
//  link_pc = p4 of the held instruction.
//  Control inputs are sampled only in a HOLD&instr_ready cycle and ignored otherwise.
//  Reset in WAIT: the outstanding response is dropped. A late rvalid arriving in IDLE/REQ is ignored.
//  imem_req never drops in REQ before imem_gnt. imem_addr is stable while imem_req=1.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - PC_SEL_SEQ=0, PC_SEL_REG=1, PC_SEL_BR=2, PC_SEL_JMP=3 (shared with the decoder)
//    - fetch state enum
//    - RESET_PC default
//  - Sub-module next_pc_calc (combinational): pc, instruction, pc_mux_sel, bcond, rs_val ->
//    next_pc, link_pc, misaligned.
//  - Top: FSM, pc/instruction/counter registers.
// TESTING
//  - Reset, then memory answers gnt immediately and rvalid next cycle with 32'h2001_0005:
//    -> imem_req rises in cycle 2 with addr 0; instr_valid=1 with that word in cycle 4.
//  - sel 0 chain at pc=0,4,8 with instr_ready held high -> imem_addr sequence 0,4,8,C; retired_cnt=3.
//  - pc=0x100, sel 2, imm=16'hFFFE, bcond=1 -> next fetch at 0xFC. Same with bcond=0 -> 0x104.
//  - pc=0x3000_0010, sel 3, iindex=26'h0000040 -> 0x3000_0100. sel 1, rs_val=0x202 -> fault=1, no further req.
//  - Backpressure: instr_ready low for 5 cycles in HOLD -> instruction and link_pc stable, no imem_req.
//  - Reset mid-op: rst_n low during WAIT, then rvalid+err -> no fault; after release, refetch from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: PC mux encodings (common with the decoder),
// fetch FSM states and the default reset PC.
package cpu_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_REG = 2'd1;
  localparam logic [1:0] PC_SEL_BR  = 2'd2;
  localparam logic [1:0] PC_SEL_JMP = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_HOLD,
    FS_FAULT
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the held instruction; also yields the
// link value and flags targets that are not word aligned.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instruction,
  input  logic [1:0]  pc_mux_sel,
  input  logic        bcond,
  input  logic [31:0] rs_val,
  output logic [31:0] next_pc,
  output logic [31:0] link_pc,
  output logic        misaligned
);

  logic [31:0] p4;
  logic [31:0] br_off;

  assign p4     = pc + 32'd4;
  assign br_off = {{14{instruction[15]}}, instruction[15:0], 2'b00};

  always_comb begin
    next_pc = p4;
    case (pc_mux_sel)
      PC_SEL_REG: next_pc = rs_val;
      PC_SEL_BR:  next_pc = bcond ? (p4 + br_off) : p4;
      PC_SEL_JMP: next_pc = {p4[31:28], instruction[25:0], 2'b00};
      default:    next_pc = p4;
    endcase
  end

  assign link_pc    = p4;
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Non-speculative single-outstanding instruction fetch: owns the PC, runs the
// imem req/gnt/rvalid handshake and holds one instruction for the decoder.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_err,
  output logic [31:0]      instruction,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic [1:0]       pc_mux_sel,
  input  logic             bcond,
  input  logic [31:0]      rs_val,
  output logic [31:0]      link_pc,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             vld_q, vld_d;
  logic             fault_q, fault_d;

  logic [31:0]      next_pc;
  logic             misaligned;

  next_pc_calc u_next_pc (
    .pc          (pc_q),
    .instruction (instr_q),
    .pc_mux_sel  (pc_mux_sel),
    .bcond       (bcond),
    .rs_val      (rs_val),
    .next_pc     (next_pc),
    .link_pc     (link_pc),
    .misaligned  (misaligned)
  );

  // Outputs are registered alongside the state so they track it exactly.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    vld_d   = vld_q;
    fault_d = fault_q;
    case (state_q)
      FS_IDLE: begin
        state_d = FS_REQ;
        req_d   = 1'b1;
      end
      FS_REQ: begin
        if (imem_gnt) begin
          state_d = FS_WAIT;
          req_d   = 1'b0;
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          if (imem_err) begin
            state_d = FS_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = FS_HOLD;
            instr_d = imem_rdata;
            vld_d   = 1'b1;
          end
        end
      end
      FS_HOLD: begin
        if (instr_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          vld_d = 1'b0;
          // A bad target still retires the instruction but leaves pc alone.
          if (misaligned) begin
            state_d = FS_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = FS_REQ;
            pc_d    = next_pc;
            req_d   = 1'b1;
          end
        end
      end
      FS_FAULT: begin
        req_d   = 1'b0;
        vld_d   = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = FS_FAULT;
        req_d   = 1'b0;
        vld_d   = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = vld_q;
  assign fault       = fault_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a memory responder with random gnt/rvalid
// delays and a PC/retire reference model driven by directed and random accepts.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_mux_sel;
  logic        bcond;
  logic [31:0] rs_val;
  logic [31:0] link_pc;
  logic        fault;
  logic [31:0] retired_cnt;

  instruction_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_mux_sel  (pc_mux_sel),
    .bcond       (bcond),
    .rs_val      (rs_val),
    .link_pc     (link_pc),
    .fault       (fault),
    .retired_cnt (retired_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] pc_exp;
  logic [31:0] cnt_exp;
  bit          fault_exp;
  logic [31:0] fetch_q[$];
  logic [31:0] fetch_log[$];
  logic [31:0] mem_ovr[logic [31:0]];
  bit          mem_auto = 1'b1;
  bit          err_next = 1'b0;
  int          g_max = 0;
  int          r_max = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Architectural next-PC rule, straight from the ISA description.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [1:0] sel, input bit bc,
                                             input logic [31:0] rs);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    case (sel)
      2'd0:    return p4;
      2'd1:    return rs;
      2'd2:    return bc ? p4 + 32'(off) : p4;
      default: return (p4 & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    endcase
  endfunction

  // Memory responder: grants after 0..g_max cycles, answers 1+0..r_max cycles later.
  initial begin
    bit          pend;
    int          gwait, rwait;
    logic [31:0] paddr;
    pend = 0; gwait = 0; rwait = 0; paddr = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      if (mem_auto) begin
        imem_gnt = 0; imem_rvalid = 0; imem_err = 0; imem_rdata = $urandom;
        if (pend) begin
          if (rwait == 0) begin
            imem_rvalid = 1; imem_rdata = mem_word(paddr); imem_err = err_next;
            err_next = 0; pend = 0;
          end else rwait--;
        end else if (imem_req === 1'b1 && rst_n) begin
          if (gwait == 0) begin
            imem_gnt = 1; paddr = imem_addr; pend = 1;
            fetch_q.push_back(imem_addr); fetch_log.push_back(imem_addr);
            rwait = int'($urandom_range(0, r_max));
            gwait = int'($urandom_range(0, g_max));
          end else gwait--;
        end
      end
    end
  end

  task automatic summary;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic model_reset;
    pc_exp = 32'h0; cnt_exp = 32'h0; fault_exp = 0;
    fetch_q.delete(); fetch_log.delete();
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (instr_valid !== 1'b1) begin
      if (n == 80) begin
        total++; bad++;
        $display("FAIL valid_timeout got=%b exp=1 pc_exp=%h", instr_valid, pc_exp);
        summary();
      end
      @(negedge clk); n++;
    end
  endtask

  task automatic accept(input logic [1:0] sel, input bit bc, input logic [31:0] rs, input int hold);
    logic [31:0] w, np, a;
    wait_valid();
    w = mem_word(pc_exp);
    total++;
    if (fetch_q.size() != 1) begin
      bad++; $display("FAIL fetch_count got=%0d exp=1", fetch_q.size());
    end else begin
      a = fetch_q.pop_front();
      total++;
      if (a !== pc_exp) begin bad++; $display("FAIL fetch_addr got=%h exp=%h", a, pc_exp); end
    end
    fetch_q.delete();
    total++;
    if (instruction !== w) begin bad++; $display("FAIL instr got=%h exp=%h", instruction, w); end
    total++;
    if (link_pc !== pc_exp + 32'd4) begin
      bad++; $display("FAIL link_pc got=%h exp=%h", link_pc, pc_exp + 32'd4);
    end
    for (int i = 0; i < hold; i++) begin
      instr_ready = 0; pc_mux_sel = 2'($urandom); bcond = 1'($urandom); rs_val = $urandom;
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instruction !== w || link_pc !== pc_exp + 32'd4 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable got=v%b i%h l%h r%b exp=v1 i%h l%h r0",
                 instr_valid, instruction, link_pc, imem_req, w, pc_exp + 32'd4);
      end
    end
    instr_ready = 1; pc_mux_sel = sel; bcond = bc; rs_val = rs;
    @(negedge clk);
    instr_ready = 0; pc_mux_sel = 2'($urandom); bcond = 1'($urandom); rs_val = $urandom;
    np = model_next(pc_exp, w, sel, bc, rs);
    cnt_exp++;
    if (np[1:0] != 2'b00) fault_exp = 1; else pc_exp = np;
    total++;
    if (retired_cnt !== cnt_exp) begin bad++; $display("FAIL retired got=%0d exp=%0d", retired_cnt, cnt_exp); end
    total++;
    if (fault !== fault_exp) begin bad++; $display("FAIL fault got=%b exp=%b", fault, fault_exp); end
    total++;
    if (imem_req !== !fault_exp || (!fault_exp && imem_addr !== pc_exp)) begin
      bad++; $display("FAIL next_req got=%b/%h exp=%b/%h", imem_req, imem_addr, !fault_exp, pc_exp);
    end
  endtask

  task automatic test_reset;
    g_max = 0; r_max = 0; mem_auto = 1;
    mem_ovr[32'h0] = 32'h2001_0005;
    instr_ready = 0; pc_mux_sel = 0; bcond = 0; rs_val = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if (imem_req !== 0 || instr_valid !== 0 || fault !== 0 || instruction !== 0 ||
        retired_cnt !== 0 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state got=r%b v%b f%b i%h c%0d a%h exp=all zero",
               imem_req, instr_valid, fault, instruction, retired_cnt, imem_addr);
    end
    model_reset();
    rst_n = 1;
    #1;
    total++;
    if (imem_req !== 0) begin bad++; $display("FAIL req_cycle1 got=%b exp=0", imem_req); end
    @(negedge clk);
    total++;
    if (imem_req !== 1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL req_cycle2 got=%b/%h exp=1/0", imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 0) begin bad++; $display("FAIL valid_cycle3 got=%b exp=0", instr_valid); end
    @(negedge clk);
    total++;
    if (instr_valid !== 1 || instruction !== 32'h2001_0005) begin
      bad++; $display("FAIL first_word got=%b/%h exp=1/20010005", instr_valid, instruction);
    end
  endtask

  task automatic test_seq;
    logic [31:0] exp_a[4];
    int n;
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) accept(2'd0, 0, 32'h0, 0);
    n = 0;
    while (fetch_log.size() < 4 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (fetch_log.size() < 4) begin
      bad++; $display("FAIL seq_fetches got=%0d exp=4", fetch_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (fetch_log[i] !== exp_a[i]) begin
          bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, fetch_log[i], exp_a[i]);
        end
      end
    end
    total++;
    if (retired_cnt !== 32'd3) begin bad++; $display("FAIL seq_retired got=%0d exp=3", retired_cnt); end
  endtask

  task automatic test_branch;
    mem_ovr[32'h100] = 32'h1000_FFFE;
    accept(2'd1, 0, 32'h100, 0);
    accept(2'd2, 1, 32'h0, 0);
    wait_valid();
    total++;
    if (imem_addr !== 32'hFC) begin bad++; $display("FAIL br_taken got=%h exp=000000fc", imem_addr); end
    accept(2'd1, 0, 32'h100, 0);
    accept(2'd2, 0, 32'h0, 0);
    wait_valid();
    total++;
    if (imem_addr !== 32'h104) begin bad++; $display("FAIL br_not_taken got=%h exp=00000104", imem_addr); end
  endtask

  task automatic test_jump;
    mem_ovr[32'h3000_0010] = 32'h0800_0040;
    accept(2'd1, 0, 32'h3000_0010, 0);
    accept(2'd3, 0, 32'h0, 0);
    wait_valid();
    total++;
    if (imem_addr !== 32'h3000_0100) begin bad++; $display("FAIL jump got=%h exp=30000100", imem_addr); end
  endtask

  task automatic test_backpressure;
    accept(2'd0, 0, 32'h0, 5);
  endtask

  task automatic test_misalign;
    accept(2'd1, 0, 32'h202, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (fault !== 1 || imem_req !== 0 || instr_valid !== 0) begin
        bad++; $display("FAIL fault_hold got=f%b r%b v%b exp=f1 r0 v0", fault, imem_req, instr_valid);
      end
    end
    total++;
    if (fetch_q.size() != 0) begin bad++; $display("FAIL fault_no_fetch got=%0d exp=0", fetch_q.size()); end
  endtask

  task automatic test_reset_mid;
    int n;
    mem_auto = 0;
    @(negedge clk);
    imem_gnt = 0; imem_rvalid = 0; imem_err = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if (fault !== 0 || retired_cnt !== 0) begin
      bad++; $display("FAIL reset_clears got=f%b c%0d exp=f0 c0", fault, retired_cnt);
    end
    model_reset();
    rst_n = 1;
    n = 0;
    while (imem_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    total++;
    if (imem_req !== 1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL mid_req got=%b/%h exp=1/0", imem_req, imem_addr);
    end
    imem_gnt = 1;
    @(negedge clk);
    imem_gnt = 0;
    rst_n = 0;
    #1;
    total++;
    if (imem_req !== 0 || instr_valid !== 0 || fault !== 0) begin
      bad++; $display("FAIL mid_reset got=r%b v%b f%b exp=0 0 0", imem_req, instr_valid, fault);
    end
    @(negedge clk);
    imem_rvalid = 1; imem_err = 1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (fault !== 0 || instr_valid !== 0) begin
      bad++; $display("FAIL late_rvalid got=f%b v%b exp=f0 v0", fault, instr_valid);
    end
    imem_rvalid = 0; imem_err = 0;
    fetch_q.delete();
    mem_auto = 1;
    accept(2'd0, 0, 32'h0, 0);
  endtask

  task automatic test_random;
    logic [1:0] sel;
    g_max = 2; r_max = 3;
    for (int k = 0; k < 40; k++) begin
      sel = 2'($urandom);
      accept(sel, 1'($urandom), $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_bus_err;
    int n;
    logic [31:0] c0;
    wait_valid();
    err_next = 1;
    accept(2'd0, 0, 32'h0, 0);
    c0 = cnt_exp;
    n = 0;
    while (fault !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (fault !== 1) begin bad++; $display("FAIL bus_err_fault got=%b exp=1", fault); end
    total++;
    if (fetch_q.size() != 1 || fetch_q[0] !== pc_exp) begin
      bad++; $display("FAIL bus_err_addr got=%0d entries exp=1 at %h", fetch_q.size(), pc_exp);
    end
    repeat (5) @(negedge clk);
    total++;
    if (imem_req !== 0 || instr_valid !== 0 || retired_cnt !== c0) begin
      bad++; $display("FAIL bus_err_quiet got=r%b v%b c%0d exp=r0 v0 c%0d", imem_req, instr_valid, retired_cnt, c0);
    end
  endtask

  initial begin
    rst_n = 0;
    instr_ready = 0; pc_mux_sel = 0; bcond = 0; rs_val = 0;
    @(negedge clk);
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_random();
    test_bus_err();
    summary();
  end

endmodule
